// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch/decode/execute sequencer.
// The CALLSTACK_EN macro enables the return-address stack in fetch_unit.
package fetch_pkg;

  localparam int DEF_OPW         = 3;
  localparam int DEF_ADW         = 5;
  localparam int DEF_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  function automatic int calc_iw(input int opw, input int adw);
    return opw + adw;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory and execute-unit signals of fetch_unit. Handshake: memory read data is
// taken in WAIT on the cycle mem_ready is high; exec_done (with its qualifiers) is taken only in EXEC.
interface fetch_if import fetch_pkg::*; #(
  parameter int OPW = DEF_OPW,
  parameter int ADW = DEF_ADW
) ();
  localparam int IW = calc_iw(OPW, ADW);

  logic [IW-1:0]  mem_rdata;
  logic           mem_ready;
  logic           mem_rd;
  logic [ADW-1:0] mem_addr;
  logic           data_sel;
  logic           exec_done;
  logic           branch_take;
  logic           halt_req;
  logic           call_req;
  logic           ret_req;
  logic [IW-1:0]  ir_q;
  logic [OPW-1:0] opcode;
  logic [ADW-1:0] operand;
  logic [ADW-1:0] pc_q;
  logic           exec_start;
  logic           halted;
  logic           stack_err;
  state_t         dbg_state;

  modport master (
    input  mem_rdata, mem_ready, data_sel, exec_done, branch_take, halt_req, call_req, ret_req,
    output mem_rd, mem_addr, ir_q, opcode, operand, pc_q, exec_start, halted, stack_err, dbg_state
  );

  modport slave (
    output mem_rdata, mem_ready, data_sel, exec_done, branch_take, halt_req, call_req, ret_req,
    input  mem_rd, mem_addr, ir_q, opcode, operand, pc_q, exec_start, halted, stack_err, dbg_state
  );
endinterface

// File: rtl/fetch_callstack.sv
// Return-address LIFO used by fetch_unit when CALLSTACK_EN is defined.
// Push on full and pop on empty are dropped; the caller flags them as faults.
module fetch_callstack #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);
   localparam int SPW = $clog2(DEPTH + 1);
   localparam int IXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]   r_mem [DEPTH];
   logic [SPW-1:0] r_sp;
   logic [SPW-1:0] w_sp_dec;
   logic [IXW-1:0] w_wr_idx;
   logic [IXW-1:0] w_top_idx;

   assign w_sp_dec  = r_sp - SPW'(1);
   assign w_wr_idx  = IXW'(r_sp);
   assign w_top_idx = IXW'(w_sp_dec);
   assign o_full    = (r_sp == SPW'(DEPTH));
   assign o_empty   = (r_sp == '0);
   assign o_top     = r_mem[w_top_idx];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sp <= '0;
      end else if (i_push && !o_full) begin
         r_sp <= r_sp + SPW'(1);
      end else if (i_pop && !o_empty) begin
         r_sp <= w_sp_dec;
      end
   end

   // Storage needs no reset: an entry is only read after it has been pushed.
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_push && !o_full) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction register / program counter with a FETCH-WAIT-DECODE-EXEC-HALT sequencer.
// Define CALLSTACK_EN to add call/return through a fetch_callstack LIFO.
module fetch_unit import fetch_pkg::*; #(
  parameter int OPW         = DEF_OPW,
  parameter int ADW         = DEF_ADW,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input logic    clock,
  input logic    Reset,
  fetch_if.master bus
);
   localparam int IW = calc_iw(OPW, ADW);

   state_t         r_state;
   logic [ADW-1:0] r_pc;
   logic [IW-1:0]  r_ir;
   logic [ADW-1:0] w_operand;
   logic [ADW-1:0] w_pc_inc;
   logic           w_mem_rd;
   logic [ADW-1:0] w_mem_addr;
   logic           w_exec_start;
   logic           w_halted;

   assign w_operand = r_ir[ADW-1:0];
   assign w_pc_inc  = r_pc + ADW'(1);

`ifdef CALLSTACK_EN
   logic           r_stack_err;
   logic           w_fire;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic [ADW-1:0] w_top;

   // halt_req outranks ret_req, which outranks call_req.
   assign w_fire = (r_state == EXEC) && bus.exec_done && !bus.halt_req;
   assign w_pop  = w_fire && bus.ret_req && !w_empty;
   assign w_push = w_fire && !bus.ret_req && bus.call_req && !w_full;

   fetch_callstack #(.DEPTH(STACK_DEPTH), .W(ADW)) u_stack (
      .i_clk   (clock),
      .i_rst   (Reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_pc),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.stack_err = r_stack_err;
`else
   localparam int unused_depth = STACK_DEPTH;
   logic w_unused_req;
   assign w_unused_req  = bus.call_req | bus.ret_req;
   assign bus.stack_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (Reset) begin
         r_state <= FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
`ifdef CALLSTACK_EN
         r_stack_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            FETCH:  r_state <= WAIT;
            WAIT: begin
               if (bus.mem_ready) begin
                  r_ir    <= bus.mem_rdata;
                  r_pc    <= w_pc_inc;
                  r_state <= DECODE;
               end
            end
            DECODE: r_state <= EXEC;
            EXEC: begin
               if (bus.exec_done) begin
                  r_state <= FETCH;
                  if (bus.halt_req) begin
                     r_state <= HALT;
`ifdef CALLSTACK_EN
                  end else if (bus.ret_req) begin
                     if (w_empty) begin
                        r_stack_err <= 1'b1;
                        r_state     <= HALT;
                     end else begin
                        r_pc <= w_top;
                     end
                  end else if (bus.call_req) begin
                     if (w_full) begin
                        r_stack_err <= 1'b1;
                        r_state     <= HALT;
                     end else begin
                        r_pc <= w_operand;
                     end
`endif
                  end else if (bus.branch_take) begin
                     r_pc <= w_operand;
                  end
               end
            end
            HALT:    r_state <= HALT;
            default: r_state <= FETCH;
         endcase
      end
   end

   always_comb begin
      w_mem_rd     = 1'b0;
      w_mem_addr   = r_pc;
      w_exec_start = 1'b0;
      w_halted     = 1'b0;
      case (r_state)
         FETCH, WAIT: w_mem_rd = 1'b1;
         DECODE:      w_exec_start = 1'b1;
         EXEC:        w_mem_addr = bus.data_sel ? w_operand : r_pc;
         HALT:        w_halted = 1'b1;
         default:     w_mem_rd = 1'b0;
      endcase
   end

   assign bus.mem_rd     = w_mem_rd;
   assign bus.mem_addr   = w_mem_addr;
   assign bus.exec_start = w_exec_start;
   assign bus.halted     = w_halted;
   assign bus.ir_q       = r_ir;
   assign bus.opcode     = r_ir[IW-1:ADW];
   assign bus.operand    = w_operand;
   assign bus.pc_q       = r_pc;
   assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an instruction-level model predicts each fetch,
// and a monitor pops those predictions when the DUT reads memory or pulses exec_start.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clock;
  logic Reset;

  fetch_if #(.OPW(3), .ADW(5)) bus ();

  fetch_unit #(.OPW(3), .ADW(5), .STACK_DEPTH(DEPTH)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expectation item: {fetch address[17:13], instruction[12:5], pc after fetch[4:0]}
  logic [17:0] exp_q[$];
  logic [3:0]  dec_q[$];
  logic [7:0]  mem [32];
  logic [4:0]  stk[$];
  logic [4:0]  model_pc;
  logic [7:0]  model_ir;
  bit          model_halted;
  bit          model_err;
  bit          chk_halt;
  bit          halt_done;
  bit          active;
  int          wait_cnt;
  int          delay_mode;
  int          n_cmp;
  int          n_fail;
  int          n_starts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [4:0] addr);
    logic [4:0] nxt;
    nxt = 5'((int'(addr) + 1) % 32);
    exp_q.push_back({addr, mem[addr], nxt});
    model_pc = nxt;
    model_ir = mem[addr];
  endtask

  // memory driver: asserts mem_ready after a chosen number of WAIT cycles; noise elsewhere
  int rd_cnt;
  int cur_delay;
  always @(negedge clock) begin
    if (Reset) begin
      rd_cnt = 0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 8'($urandom);
    end else if (bus.mem_rd) begin
      rd_cnt++;
      if (rd_cnt == 1) begin
        cur_delay = (delay_mode < 0) ? $urandom_range(0, 3) : delay_mode;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
      end else if (rd_cnt >= 2 + cur_delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'($urandom);
      end
    end else begin
      rd_cnt = 0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = 8'($urandom);
    end
  end

  // execute-unit driver holding the reference model
  always @(negedge clock) begin : exec_drv
    logic [3:0] d;
    logic [4:0] opnd;
    logic [4:0] exp_addr;
    if (Reset) begin
      exp_q.delete();
      stk.delete();
      model_halted = 0;
      model_err    = 0;
      chk_halt     = 0;
      halt_done    = 0;
      active       = 0;
      push_fetch(5'd0);
      bus.exec_done = 1'b0;
    end else begin
      if (chk_halt) begin
        check("halted", 32'(bus.halted), 32'd1);
        check("halt_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("halt_pc", 32'(bus.pc_q), 32'(model_pc));
        check("halt_stack_err", 32'(bus.stack_err), 32'(model_err));
        chk_halt  = 0;
        halt_done = 1;
      end
      bus.exec_done   = 1'b0;
      bus.halt_req    = 1'($urandom_range(0, 1));
      bus.branch_take = 1'($urandom_range(0, 1));
      bus.call_req    = 1'($urandom_range(0, 1));
      bus.ret_req     = 1'($urandom_range(0, 1));
      if (bus.exec_start) begin
        active        = 1;
        wait_cnt      = $urandom_range(0, 3);
        bus.exec_done = 1'b1;
        bus.data_sel  = 1'($urandom_range(0, 1));
      end else if (active) begin
        exp_addr = bus.data_sel ? model_ir[4:0] : model_pc;
        check("exec_mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        check("exec_mem_rd", 32'(bus.mem_rd), 32'd0);
        bus.data_sel = 1'($urandom_range(0, 1));
        if (wait_cnt == 0) begin
          if (dec_q.size() > 0) d = dec_q.pop_front();
          else d = {($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))};
          bus.halt_req    = d[3];
          bus.ret_req     = d[2];
          bus.call_req    = d[1];
          bus.branch_take = d[0];
          bus.exec_done   = 1'b1;
          active = 0;
          opnd = model_ir[4:0];
          if (d[3]) begin
            model_halted = 1;
            chk_halt     = 1;
`ifdef CALLSTACK_EN
          end else if (d[2]) begin
            if (stk.size() == 0) begin
              model_err = 1; model_halted = 1; chk_halt = 1;
            end else begin
              push_fetch(stk.pop_back());
            end
          end else if (d[1]) begin
            if (stk.size() == DEPTH) begin
              model_err = 1; model_halted = 1; chk_halt = 1;
            end else begin
              stk.push_back(model_pc);
              push_fetch(opnd);
            end
`endif
          end else if (d[0]) begin
            push_fetch(opnd);
          end else begin
            push_fetch(model_pc);
          end
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clock) begin
    if (!Reset) begin
      if (bus.mem_rd) begin
        if (exp_q.size() == 0) check("unexpected_fetch", 32'(bus.mem_addr), 32'hFFFF);
        else check("fetch_addr", 32'(bus.mem_addr), 32'(exp_q[0][17:13]));
      end
      if (bus.exec_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          check("unexpected_exec_start", 32'(bus.ir_q), 32'hFFFF);
        end else begin
          check("ir_q", 32'(bus.ir_q), 32'(exp_q[0][12:5]));
          check("pc_q", 32'(bus.pc_q), 32'(exp_q[0][4:0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ir_q", 32'(bus.ir_q), 32'd0);
    check("rst_pc_q", 32'(bus.pc_q), 32'd0);
    check("rst_stack_err", 32'(bus.stack_err), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("rst_state", 32'(bus.dbg_state), 32'(FETCH));
    Reset = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int g;
    g = 0;
    while (!halt_done && g < 400) begin
      @(posedge clock); #1;
      g++;
    end
    if (!halt_done) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  initial begin : main
    int cnt;
    int g;
    int s0;
    n_cmp = 0; n_fail = 0; n_starts = 0;
    Reset = 1'b1;
    bus.mem_ready = 0; bus.mem_rdata = 0; bus.data_sel = 0; bus.exec_done = 0;
    bus.branch_take = 0; bus.halt_req = 0; bus.call_req = 0; bus.ret_req = 0;

    // first fetch with immediate mem_ready, then halt
    randomize_mem();
    mem[0] = 8'hA3;
    delay_mode = 0;
    do_reset();
    dec_q.push_back(4'b1000);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (bus.exec_start) break;
    end
    check("start_latency", 32'(cnt), 32'd3);
    check("opcode", 32'(bus.opcode), 32'd5);
    check("operand", 32'(bus.operand), 32'h03);
    wait_halt("halt1");
    repeat (4) @(negedge clock);
    check("halt_hold", 32'(bus.halted), 32'd1);
    check("halt_hold_pc", 32'(bus.pc_q), 32'(model_pc));

    // delayed memory, wrap at 1F, branch, halt beating branch
    randomize_mem();
    mem[0]     = {3'b010, 5'h1F};
    mem[5'h1F] = {3'b001, 5'h0C};
    delay_mode = 4;
    do_reset();
    dec_q.push_back(4'b0001);
    dec_q.push_back(4'b0001);
    dec_q.push_back(4'b1001);
    wait_halt("halt2");

`ifdef CALLSTACK_EN
    // five nested calls overflow a four-deep stack
    for (int i = 0; i < 32; i++) mem[i] = {3'b011, 5'((i + 2) % 32)};
    delay_mode = 0;
    do_reset();
    repeat (5) dec_q.push_back(4'b0010);
    wait_halt("overflow");

    // call from pc 06 to 10, then return to 06
    randomize_mem();
    mem[0]     = {3'b000, 5'h05};
    mem[5'h05] = {3'b100, 5'h10};
    do_reset();
    dec_q.push_back(4'b0001);
    dec_q.push_back(4'b0010);
    dec_q.push_back(4'b0100);
    dec_q.push_back(4'b1000);
    wait_halt("call_ret");
`endif

    // random traffic, restarting after every halt
    delay_mode = -1;
    randomize_mem();
    do_reset();
    s0 = n_starts;
    g  = 0;
    while ((n_starts - s0) < 80 && g < 20000) begin
      @(posedge clock); #1;
      g++;
      if (halt_done) begin
        randomize_mem();
        do_reset();
      end
    end
    check("random_progress", 32'(g < 20000), 32'd1);

    // reset in WAIT while mem_ready is high
    g = 0;
    while (!(bus.dbg_state == WAIT && (bus.ir_q != 0)) && g < 2000) begin
      @(posedge clock); #1;
      g++;
      if (halt_done) begin
        randomize_mem();
        do_reset();
      end
    end
    check("find_wait", 32'(g < 2000), 32'd1);
    Reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_ir_q", 32'(bus.ir_q), 32'd0);
    check("midrst_pc_q", 32'(bus.pc_q), 32'd0);
    check("midrst_state", 32'(bus.dbg_state), 32'(FETCH));
    do_reset();
    repeat (20) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
